// File: rtl/bin2bcd_if.sv
// Request/result bundle between a binary producer and the bin2bcd converter.
interface bin2bcd_if;
  logic       start;
  logic [9:0] bin;
  logic       ready;
  logic       done_tick;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;

  modport master (
    output start, bin,
    input  ready, done_tick, bcd3, bcd2, bcd1, bcd0
  );

  modport slave (
    input  start, bin,
    output ready, done_tick, bcd3, bcd2, bcd1, bcd0
  );
endinterface

// File: rtl/bin2bcd.sv
// 10-bit binary to 4-digit BCD, double-dabble one bit per clock; result and done_tick 10 cycles after accept.
// start is taken only while ready=1 (idle); outputs hold the previous result until the next done_tick.
module bin2bcd (
  input  logic    clk,
  input  logic    reset_n,
  bin2bcd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  counter;
  logic [15:0] bcd_shift;
  logic [9:0]  bin_shift;
  logic [15:0] adj;
  logic [15:0] nxt_bcd;

  // Add-3 correction per nibble, then shift in the next binary MSB.
  always_comb begin
    adj = bcd_shift;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    nxt_bcd = (adj << 1) | {15'd0, bin_shift[9]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      counter       <= 4'd0;
      bcd_shift     <= 16'd0;
      bin_shift     <= 10'd0;
      bus.bcd3      <= 4'd0;
      bus.bcd2      <= 4'd0;
      bus.bcd1      <= 4'd0;
      bus.bcd0      <= 4'd0;
      bus.ready     <= 1'b1;
      bus.done_tick <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_shift <= bus.bin;
            bcd_shift <= 16'd0;
            counter   <= 4'd10;
            state     <= CONV;
            bus.ready <= 1'b0;
          end
        end
        CONV: begin
          bcd_shift <= nxt_bcd;
          bin_shift <= {bin_shift[8:0], 1'b0};
          counter   <= counter - 4'd1;
          // Last iteration: publish the final value on the edge entering DONE.
          if (counter == 4'd1) begin
            state         <= DONE;
            bus.done_tick <= 1'b1;
            {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} <= nxt_bcd;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.done_tick <= 1'b0;
          bus.ready     <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.done_tick <= 1'b0;
          bus.ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd.sv
// Self-checking bench for bin2bcd: directed corners plus random and exhaustive operands against a decimal model.
module tb_bin2bcd;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  bin2bcd_if bif ();

  bin2bcd dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] outs();
    return {bif.bcd3, bif.bcd2, bif.bcd1, bif.bcd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One framed conversion; optional start pulse mid-conversion must be ignored.
  task automatic run_conv(input string tag, input int v, input bit pulse_mid);
    logic [15:0] prev;
    int          holds_bad;
    int          dones;
    int          done_at;
    holds_bad = 0;
    dones     = 0;
    done_at   = -1;
    prev      = outs();
    check({tag, "_ready_pre"}, 32'(bif.ready), 32'd1);
    bif.bin   = 10'(v);
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.bin   = 10'($urandom_range(0, 1023));
    for (int k = 1; k <= 11; k++) begin
      if (pulse_mid && k == 4) bif.start = 1'b1;
      if (pulse_mid && k == 5) bif.start = 1'b0;
      @(posedge clk);
      #1;
      if (bif.done_tick) begin
        dones++;
        done_at = k;
      end
      if (k < 10 && outs() !== prev) holds_bad++;
      if (k == 10) check({tag, "_result"}, 32'(outs()), 32'(model(v)));
      if (k < 11 && bif.ready) holds_bad++;
    end
    check({tag, "_done_at"}, 32'(done_at), 32'd10);
    check({tag, "_done_cnt"}, 32'(dones), 32'd1);
    check({tag, "_hold"}, 32'(holds_bad), 32'd0);
    check({tag, "_ready_post"}, 32'(bif.ready), 32'd1);
  endtask

  initial begin
    logic [15:0] prev;
    int          cnt;
    int          n;
    int          budget;
    int          hold_err;
    int          v;
    errors      = 0;
    checks      = 0;
    reset_n     = 1'b0;
    bif.start   = 1'b0;
    bif.bin     = 10'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 32'(outs()), 32'd0);
    check("rst_ready", 32'(bif.ready), 32'd1);
    check("rst_done", 32'(bif.done_tick), 32'd0);
    reset_n = 1'b1;

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bif.bin = 10'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      if (outs() !== 16'd0 || !bif.ready || bif.done_tick) cnt++;
    end
    check("idle_stable", 32'(cnt), 32'd0);

    run_conv("zero", 0, 1'b0);
    run_conv("max", 1023, 1'b0);
    run_conv("n999", 999, 1'b0);
    run_conv("n599", 599, 1'b0);
    run_conv("n4", 4, 1'b0);
    run_conv("n5", 5, 1'b0);
    run_conv("ignored", 255, 1'b1);

    // Reset while converting 512: E5 samples reset_n=0.
    bif.bin   = 10'd512;
    bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_outs", 32'(outs()), 32'd0);
    check("midrst_ready", 32'(bif.ready), 32'd1);
    check("midrst_done", 32'(bif.done_tick), 32'd0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bif.done_tick) cnt++;
    end
    check("midrst_no_done", 32'(cnt), 32'd0);
    run_conv("after_rst", 42, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_conv("rand", int'($urandom_range(0, 1023)), 1'b0);
    end

    // Back-to-back sweep with start held high.
    bif.start = 1'b1;
    hold_err  = 0;
    for (v = 0; v < 1024; v++) begin
      budget = 0;
      while (!bif.ready && budget < 20) begin
        @(posedge clk);
        #1;
        budget++;
      end
      if (!bif.ready) begin
        check("sweep_ready_timeout", 32'(bif.ready), 32'd1);
        break;
      end
      bif.bin = 10'(v);
      prev    = outs();
      @(posedge clk);
      #1;
      bif.bin = 10'($urandom_range(0, 1023));
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
        if (!bif.done_tick && outs() !== prev) hold_err++;
      end while (!bif.done_tick && n < 15);
      check("sweep_latency", 32'(n), 32'd10);
      check("sweep_result", 32'(outs()), 32'(model(v)));
    end
    bif.start = 1'b0;
    check("sweep_hold", 32'(hold_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
